// File: rtl/ram_lsu_if.sv
// Bus bundle between the core memory stage, the load/store unit and the SPRAM.
//
// Request handshake: a request transfers on a rising clk edge where
// req_valid && req_ready are both high. The requester holds all req_* fields
// stable while req_valid is high. rsp_valid is a single-cycle pulse that has no
// ready; the requester must take rsp_rdata in that cycle.
interface ram_lsu_if #(
  parameter int ADR_W = 14
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_signed;
  logic [ADR_W+1:0] req_addr;
  logic [31:0]      req_wdata;
  logic             rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             mem_cs;
  logic [3:0]       mem_wren;
  logic [ADR_W-1:0] mem_adr;
  logic [31:0]      mem_di;
  logic [31:0]      mem_do;

  // The load/store unit's view of the bus.
  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_do,
    output req_ready, rsp_valid, rsp_rdata, mem_cs, mem_wren, mem_adr, mem_di
  );

  // The environment's view: core request side plus the RAM.
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_do,
    input  req_ready, rsp_valid, rsp_rdata, mem_cs, mem_wren, mem_adr, mem_di
  );
endinterface

// File: rtl/ram_lsu.sv
// Load/store unit for a 32-bit single-port SPRAM with byte write enables.
// Handles byte/half/word accesses at any byte offset; accesses crossing a word
// boundary are split into two RAM cycles and the read data is merged and
// sign/zero-extended before being returned.
module ram_lsu #(
  parameter int ADR_W = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  ram_lsu_if.slave    bus,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {IDLE, ACC1, ACC2, FIN, RESP} state_t;

  state_t           state, state_nx;

  logic             r_we;
  logic [1:0]       r_size;
  logic             r_signed;
  logic [1:0]       r_off;
  logic [ADR_W-1:0] r_wadr;
  logic [31:0]      r_wdata;
  logic             r_split;
  logic [31:0]      lo_buf;

  logic             accept;
  logic [3:0]       first_wren;
  logic [31:0]      first_di;
  logic [2:0]       sec_sh;
  logic [3:0]       sec_wren;
  logic [31:0]      sec_di;
  logic [31:0]      lo_word, hi_word, merged, load_data;

  // Byte-lane mask for the access size, right-aligned (reserved size = word).
  function automatic logic [3:0] size_mask(input logic [1:0] s);
    case (s)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  // An access needs a second word when offset + bytes exceeds 4.
  function automatic logic needs_split(input logic [1:0] s, input logic [1:0] o);
    case (s)
      2'b00:   needs_split = 1'b0;
      2'b01:   needs_split = (o == 2'd3);
      default: needs_split = (o != 2'd0);
    endcase
  endfunction

  assign accept        = (state == IDLE) && bus.req_valid;
  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign dbg_state     = state;

  // Lane geometry: first access comes straight from the request (it is
  // registered on the accept edge), second access from the latched fields.
  always_comb begin
    first_wren = size_mask(bus.req_size) << bus.req_addr[1:0];
    first_di   = bus.req_wdata << {bus.req_addr[1:0], 3'b000};
    sec_sh     = 3'd4 - {1'b0, r_off};
    sec_wren   = size_mask(r_size) >> sec_sh;
    sec_di     = r_wdata >> {sec_sh, 3'b000};
  end

  // Load merge: {hi, lo} shifted down by the byte offset, then extended.
  always_comb begin
    lo_word = r_split ? lo_buf : bus.mem_do;
    hi_word = r_split ? bus.mem_do : 32'h0;
    merged  = 32'({hi_word, lo_word} >> {r_off, 3'b000});
    case (r_size)
      2'b00:   load_data = r_signed ? {{24{merged[7]}}, merged[7:0]}
                                    : {24'h0, merged[7:0]};
      2'b01:   load_data = r_signed ? {{16{merged[15]}}, merged[15:0]}
                                    : {16'h0, merged[15:0]};
      default: load_data = merged;
    endcase
    if (r_we) load_data = 32'h0;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nx = ACC1;
      ACC1:    state_nx = r_split ? ACC2 : FIN;
      ACC2:    state_nx = FIN;
      FIN:     state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Request latch, registered RAM drive and read-data capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we          <= 1'b0;
      r_size        <= 2'b00;
      r_signed      <= 1'b0;
      r_off         <= 2'b00;
      r_wadr        <= '0;
      r_wdata       <= 32'h0;
      r_split       <= 1'b0;
      lo_buf        <= 32'h0;
      bus.mem_cs    <= 1'b0;
      bus.mem_wren  <= 4'b0000;
      bus.mem_adr   <= '0;
      bus.mem_di    <= 32'h0;
      bus.rsp_rdata <= 32'h0;
    end else begin
      bus.mem_cs   <= 1'b0;
      bus.mem_wren <= 4'b0000;
      case (state)
        IDLE: begin
          if (accept) begin
            r_we         <= bus.req_we;
            r_size       <= bus.req_size;
            r_signed     <= bus.req_signed;
            r_off        <= bus.req_addr[1:0];
            r_wadr       <= bus.req_addr[ADR_W+1:2];
            r_wdata      <= bus.req_wdata;
            r_split      <= needs_split(bus.req_size, bus.req_addr[1:0]);
            bus.mem_cs   <= 1'b1;
            bus.mem_adr  <= bus.req_addr[ADR_W+1:2];
            bus.mem_wren <= bus.req_we ? first_wren : 4'b0000;
            bus.mem_di   <= first_di;
          end
        end
        ACC1: begin
          if (r_split) begin
            bus.mem_cs   <= 1'b1;
            bus.mem_adr  <= r_wadr + {{(ADR_W-1){1'b0}}, 1'b1};
            bus.mem_wren <= r_we ? sec_wren : 4'b0000;
            bus.mem_di   <= sec_di;
          end
        end
        ACC2: lo_buf <= bus.mem_do;
        FIN: begin
          if (!r_split) lo_buf <= bus.mem_do;
          bus.rsp_rdata <= load_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_lsu.sv
// Bench for ram_lsu: directed table, hand-written split/abort sequences and
// randomized traffic checked against a byte-addressed memory model.
module tb_ram_lsu;
  localparam int ADR_W = 14;
  localparam int AW    = ADR_W + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_lsu_if #(.ADR_W(ADR_W)) bus ();
  logic [2:0] dbg_state;

  ram_lsu #(.ADR_W(ADR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- SPRAM model ----------------
  logic [31:0]      ram [0:(1<<ADR_W)-1];
  logic             ld_en = 1'b0;
  logic [ADR_W-1:0] ld_adr = '0;
  logic [31:0]      ld_data = 32'h0;

  always @(posedge clk) begin
    if (ld_en) ram[ld_adr] <= ld_data;
    else if (bus.mem_cs)
      for (int i = 0; i < 4; i++)
        if (bus.mem_wren[i]) ram[bus.mem_adr][8*i +: 8] <= bus.mem_di[8*i +: 8];
    bus.mem_do <= bus.mem_cs ? ram[bus.mem_adr] : 32'h0;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [7:0]  ref_mem [0:(1<<AW)-1];
  logic [31:0] exp_q[$];
  int          pass_cnt = 0;
  int          total = 0;
  logic [31:0] last_di1, last_di2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Byte-level model: walks the n bytes of the access one at a time.
  task automatic model_access(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [AW-1:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output int lat,
                              output logic [3:0] m1, output logic [3:0] m2,
                              output logic [ADR_W-1:0] a1, output logic [ADR_W-1:0] a2);
    int n;
    logic [AW-1:0] b;
    logic [31:0] val;
    n  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    a1 = addr[AW-1:2];
    a2 = a1 + 14'd1;
    m1 = 4'b0; m2 = 4'b0; val = 32'h0;
    for (int k = 0; k < n; k++) begin
      b = addr + AW'(k);
      if (b[AW-1:2] == a1) m1[b[1:0]] = 1'b1;
      else                 m2[b[1:0]] = 1'b1;
      if (we) ref_mem[b] = wdata[8*k +: 8];
      else    val[8*k +: 8] = ref_mem[b];
    end
    for (int k = n; k < 4; k++) val[8*k +: 8] = (sgn && val[8*n-1]) ? 8'hFF : 8'h00;
    lat   = (m2 != 4'b0) ? 4 : 3;
    rdata = we ? 32'h0 : val;
    if (!we) begin m1 = 4'b0; m2 = 4'b0; end
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [AW-1:0] addr, input logic [31:0] wdata,
                        input string name, output logic [31:0] got_rd, output int got_lat);
    logic [31:0] erd, exp;
    int elat, g;
    logic [3:0] em1, em2, w1, w2;
    logic [ADR_W-1:0] ea1, ea2, ad1, ad2;
    logic cs1, cs2, busy_ok;
    model_access(we, size, sgn, addr, wdata, erd, elat, em1, em2, ea1, ea2);
    exp_q.push_back(erd);
    g = 0;
    while (!bus.req_ready && g < 20) begin @(negedge clk); g++; end
    if (!bus.req_ready) chk({name, " ready_timeout"}, 32'(bus.req_ready), 32'd1);
    bus.req_we = we; bus.req_size = size; bus.req_signed = sgn;
    bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    got_lat = 0; got_rd = 32'h0; busy_ok = 1'b1;
    cs1 = 1'b0; cs2 = 1'b0; w1 = 4'b0; w2 = 4'b0; ad1 = '0; ad2 = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin cs1 = bus.mem_cs; w1 = bus.mem_wren; ad1 = bus.mem_adr; last_di1 = bus.mem_di; end
      if (k == 2) begin cs2 = bus.mem_cs; w2 = bus.mem_wren; ad2 = bus.mem_adr; last_di2 = bus.mem_di; end
      if (bus.req_ready) busy_ok = 1'b0;
      if (bus.rsp_valid) begin got_lat = k; got_rd = bus.rsp_rdata; break; end
    end
    chk({name, " latency"}, 32'(got_lat), 32'(elat));
    exp = exp_q.pop_front();
    chk({name, " rdata"}, got_rd, exp);
    chk({name, " cs1"}, 32'(cs1), 32'd1);
    chk({name, " adr1"}, 32'(ad1), 32'(ea1));
    chk({name, " wren1"}, 32'(w1), 32'(em1));
    if (elat == 4) begin
      chk({name, " cs2"}, 32'(cs2), 32'd1);
      chk({name, " adr2"}, 32'(ad2), 32'(ea2));
      chk({name, " wren2"}, 32'(w2), 32'(em2));
    end else begin
      chk({name, " cs2_idle"}, 32'(cs2), 32'd0);
    end
    chk({name, " ready_low_busy"}, 32'(busy_ok), 32'd1);
    if (got_lat != 0) begin
      @(negedge clk);
      chk({name, " rsp_pulse"}, 32'(bus.rsp_valid), 32'd0);
      chk({name, " ready_back"}, 32'(bus.req_ready), 32'd1);
      chk({name, " rdata_hold"}, bus.rsp_rdata, got_rd);
    end
  endtask

  task automatic preload(input logic [ADR_W-1:0] w, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_adr = w; ld_data = d;
    for (int i = 0; i < 4; i++) ref_mem[{w, 2'(i)}] = d[8*i +: 8];
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic            we;
    logic [1:0]      size;
    logic            sgn;
    logic [AW-1:0]   addr;
    logic [31:0]     wdata;
    logic [31:0]     exp_rdata;
    int              exp_lat;
  } vec_t;

  vec_t vecs[18];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rd;
    int lat;
    logic saw_rsp;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = 32'h0;

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF, 32'h00000000, 3};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF, 3};
    vecs[2]  = '{1'b1, 2'd2, 1'b0, 16'h0010, 32'h80FF1234, 32'h00000000, 3};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 16'h0013, 32'h0,        32'hFFFFFF80, 3};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 16'h0013, 32'h0,        32'h00000080, 3};
    vecs[5]  = '{1'b0, 2'd1, 1'b1, 16'h0012, 32'h0,        32'hFFFF80FF, 3};
    vecs[6]  = '{1'b0, 2'd3, 1'b1, 16'h0010, 32'h0,        32'h80FF1234, 3};
    vecs[7]  = '{1'b0, 2'd2, 1'b0, 16'h0006, 32'h0,        32'h66554433, 4};
    vecs[8]  = '{1'b1, 2'd1, 1'b0, 16'h0003, 32'h0000ABCD, 32'h00000000, 4};
    vecs[9]  = '{1'b0, 2'd1, 1'b0, 16'h0003, 32'h0,        32'h0000ABCD, 4};
    vecs[10] = '{1'b0, 2'd1, 1'b1, 16'h0003, 32'h0,        32'hFFFFABCD, 4};
    vecs[11] = '{1'b1, 2'd2, 1'b0, 16'hFFFD, 32'h11223344, 32'h00000000, 4};
    vecs[12] = '{1'b0, 2'd2, 1'b1, 16'hFFFD, 32'h0,        32'h11223344, 4};
    vecs[13] = '{1'b0, 2'd0, 1'b1, 16'hFFFD, 32'h0,        32'h00000044, 3};
    vecs[14] = '{1'b0, 2'd1, 1'b1, 16'hFFFF, 32'h0,        32'h00001122, 4};
    vecs[15] = '{1'b0, 2'd0, 1'b1, 16'h0000, 32'h0,        32'h00000011, 3};
    vecs[16] = '{1'b1, 2'd0, 1'b0, 16'h0021, 32'hFFFFFFA5, 32'h00000000, 3};
    vecs[17] = '{1'b0, 2'd0, 1'b1, 16'h0021, 32'h0,        32'hFFFFFFA5, 3};

    // Preload the word ranges the test touches, still in reset.
    for (int w = 0; w < 34; w++) preload(ADR_W'(w), $urandom);
    for (int w = 16'h3FF0; w < 16'h4000; w++) preload(ADR_W'(w), $urandom);
    preload(14'd1, 32'h44332211);
    preload(14'd2, 32'h88776655);

    @(negedge clk);
    chk("reset mem_cs", 32'(bus.mem_cs), 32'd0);
    chk("reset mem_wren", 32'(bus.mem_wren), 32'd0);
    chk("reset mem_adr", 32'(bus.mem_adr), 32'd0);
    chk("reset mem_di", bus.mem_di, 32'd0);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset req_ready", 32'(bus.req_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      do_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
             $sformatf("vec%0d", i), rd, lat);
      chk($sformatf("vec%0d table_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d table_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      case (i)
        0:  chk("word store di", last_di1, 32'hDEADBEEF);
        8: begin
          chk("split half di1 lane3", 32'(last_di1[31:24]), 32'hCD);
          chk("split half di2 lane0", 32'(last_di2[7:0]), 32'hAB);
        end
        11: begin
          chk("wrap di1 lanes321", 32'(last_di1[31:8]), 32'h223344);
          chk("wrap di2 lane0", 32'(last_di2[7:0]), 32'h11);
        end
        default: ;
      endcase
    end

    // Reset during the second access of a split load: abandoned, no response.
    bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_signed = 1'b0;
    bus.req_addr = 16'h0006; bus.req_wdata = 32'h0; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort acc2 cs", 32'(bus.mem_cs), 32'd1);
    chk("abort acc2 adr", 32'(bus.mem_adr), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort mem_cs", 32'(bus.mem_cs), 32'd0);
    chk("abort mem_wren", 32'(bus.mem_wren), 32'd0);
    chk("abort mem_adr", 32'(bus.mem_adr), 32'd0);
    chk("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort rsp_rdata", bus.rsp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort ready after reset", 32'(bus.req_ready), 32'd1);
    saw_rsp = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (bus.rsp_valid) saw_rsp = 1'b1;
      @(negedge clk);
    end
    chk("abort no response", 32'(saw_rsp), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 16'h0006, 32'h0, "after_abort", rd, lat);
    chk("after_abort table_rdata", rd, 32'h66554433);

    // Randomized traffic around both ends of the address space.
    for (int t = 0; t < 200; t++) begin
      logic [AW-1:0] a;
      if ($urandom_range(0, 1) == 0) a = AW'($urandom_range(0, 127));
      else                            a = AW'(16'hFFC0 + $urandom_range(0, 63));
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, "rand", rd, lat);
    end

    // RAM image against the byte model over every word touched.
    @(negedge clk);
    begin
      int mism;
      mism = 0;
      for (int w = 0; w < 1 << ADR_W; w++) begin
        if (w < 34 || w >= 16'h3FF0)
          for (int i = 0; i < 4; i++)
            if (ram[w][8*i +: 8] !== ref_mem[{ADR_W'(w), 2'(i)}]) mism++;
      end
      chk("mem image byte mismatches", 32'(mism), 32'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
